ext_msg_page_writer: RTL and testbench

Downstream of the level-2 message-passing permutation (len-17 QSN). Accepts one permuted, bit-plane-organised message vector per beat and transposes it to lane-major order. Buffers it in a small FIFO and issues page writes to the extrinsic message RAM with per-beat page addresses. A per-layer beat sequencer brackets each layer and reports completion once every beat has been written.

---
 rtl/ext_msg_page_writer.sv | 166 ++++++++++++++++
 tb/tb_ext_msg_page_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_msg_page_writer.sv
// Extrinsic message page writer: transposes bit-plane message vectors to lane-major
// order, buffers them in a small FIFO and issues per-beat page writes for each layer.
module ext_msg_page_writer #(
  parameter int SHIFT_LENGTH    = 17,
  parameter int QUAN_SIZE       = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int PAGE_ADDR_WIDTH = 6,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                              sys_clk,
  input  logic                              rst,
  input  logic [SHIFT_LENGTH-1:0]           msg_bit0_i,
  input  logic [SHIFT_LENGTH-1:0]           msg_bit1_i,
  input  logic [SHIFT_LENGTH-1:0]           msg_bit2_i,
  input  logic [SHIFT_LENGTH-1:0]           msg_bit3_i,
  input  logic [PAGE_ADDR_WIDTH-1:0]        msg_page_addr_i,
  input  logic                              msg_valid_i,
  output logic                              msg_ready_o,
  input  logic                              layer_start_i,
  input  logic [LEN_WIDTH-1:0]              layer_len_i,
  output logic [SHIFT_LENGTH*QUAN_SIZE-1:0] pageWr_data_o,
  output logic [PAGE_ADDR_WIDTH-1:0]        pageWr_addr_o,
  output logic                              pageWr_en_o,
  input  logic                              pageWr_ready_i,
  output logic                              layer_done_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = SHIFT_LENGTH * QUAN_SIZE;

  // DONE is the one-cycle tail of draining; it carries the layer_done pulse.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [SHIFT_LENGTH-1:0]    planes [4];
  logic [DATA_W-1:0]          lane_data;
  logic [DATA_W-1:0]          mem_data [FIFO_DEPTH];
  logic [PAGE_ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [LEN_WIDTH-1:0]       acc_q;
  logic [LEN_WIDTH-1:0]       acc_inc;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       err_event;

  assign planes[0] = msg_bit0_i;
  assign planes[1] = msg_bit1_i;
  assign planes[2] = msg_bit2_i;
  assign planes[3] = msg_bit3_i;

  always_comb begin
    lane_data = '0;
    for (int unsigned l = 0; l < SHIFT_LENGTH; l++) begin
      for (int unsigned b = 0; b < QUAN_SIZE; b++) begin
        lane_data[l*QUAN_SIZE+b] = planes[b][l];
      end
    end
  end

  assign fifo_full  = count[CNT_W-1];
  assign fifo_empty = (count == '0);
  assign push       = msg_valid_i & msg_ready_o;
  assign pop        = pageWr_en_o & pageWr_ready_i;
  assign acc_inc    = acc_q + 1'b1;

  // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= lane_data;
        mem_addr[wr_ptr] <= msg_page_addr_i;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pageWr_data_o = mem_data[rd_ptr];
  assign pageWr_addr_o = mem_addr[rd_ptr];
  assign pageWr_en_o   = ~fifo_empty;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      len_q <= '0;
      acc_q <= '0;
    end else if (state == IDLE && layer_start_i) begin
      len_q <= layer_len_i;
      acc_q <= '0;
    end else if (push) begin
      acc_q <= acc_inc;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (layer_start_i) begin
          state_next = (layer_len_i != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (push && acc_inc == len_q) begin
          state_next = DRAIN;
        end
      end
      // Leave once the FIFO is empty after any pop in flight this cycle.
      DRAIN: begin
        if (fifo_empty || (count == CNT_W'(1) && pop)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    msg_ready_o  = (state == RUN) && !fifo_full && (acc_q < len_q);
    busy_o       = (state != IDLE);
    layer_done_o = (state == DONE);
  end

  assign err_event = (msg_valid_i && state != RUN) || (layer_start_i && busy_o);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (err_event) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_msg_page_writer.sv
// Directed self-checking bench for ext_msg_page_writer: single beat, backpressure,
// streaming with wrap-around, protocol errors, zero-length layer and mid-layer reset.
module tb_ext_msg_page_writer;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [16:0] msg_bit0_i, msg_bit1_i, msg_bit2_i, msg_bit3_i;
  logic [5:0]  msg_page_addr_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic        layer_start_i;
  logic [7:0]  layer_len_i;
  logic [67:0] pageWr_data_o;
  logic [5:0]  pageWr_addr_o;
  logic        pageWr_en_o;
  logic        pageWr_ready_i;
  logic        layer_done_o;
  logic        busy_o;
  logic        err_o;

  int n_assert = 0;
  int n_fail   = 0;

  ext_msg_page_writer #(
    .SHIFT_LENGTH(17), .QUAN_SIZE(4), .FIFO_DEPTH(4), .PAGE_ADDR_WIDTH(6), .LEN_WIDTH(8)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .msg_bit0_i(msg_bit0_i), .msg_bit1_i(msg_bit1_i),
    .msg_bit2_i(msg_bit2_i), .msg_bit3_i(msg_bit3_i),
    .msg_page_addr_i(msg_page_addr_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .layer_start_i(layer_start_i), .layer_len_i(layer_len_i),
    .pageWr_data_o(pageWr_data_o), .pageWr_addr_o(pageWr_addr_o),
    .pageWr_en_o(pageWr_en_o), .pageWr_ready_i(pageWr_ready_i),
    .layer_done_o(layer_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lane_val(input int k, input int l);
    if (k == 0 && l == 0)  return 4'hA;
    if (k == 0 && l == 16) return 4'h5;
    return 4'((k * 7 + l * 3 + 1) & 15);
  endfunction

  function automatic logic [5:0] addr_of(input int k);
    return 6'((k * 5 + 3) & 63);
  endfunction

  function automatic logic [67:0] exp_data(input int k);
    logic [67:0] d;
    d = '0;
    for (int l = 0; l < 17; l++) d[l*4 +: 4] = lane_val(k, l);
    return d;
  endfunction

  task automatic drive_beat(input int k);
    logic [3:0] v;
    for (int l = 0; l < 17; l++) begin
      v = lane_val(k, l);
      msg_bit0_i[l] = v[0];
      msg_bit1_i[l] = v[1];
      msg_bit2_i[l] = v[2];
      msg_bit3_i[l] = v[3];
    end
    msg_page_addr_i = addr_of(k);
  endtask

  task automatic start_layer(input int len);
    layer_start_i = 1'b1;
    layer_len_i   = 8'(len);
    tick;
    layer_start_i = 1'b0;
  endtask

  // Feeds beats feed_k..last_k, checks every write against beats first_w..last_k in
  // order, and checks the done pulse lands one cycle after the final write.
  task automatic stream(input int feed_k, input int first_w, input int last_k);
    int wr_k, last_wr, done_cnt, bubbles;
    bit started, feed_ok, pop_ok, finished;
    wr_k = first_w; last_wr = -10; done_cnt = 0; bubbles = 0;
    started = 0; finished = 0;
    if (feed_k <= last_k) begin
      drive_beat(feed_k);
      msg_valid_i = 1'b1;
    end else begin
      msg_valid_i = 1'b0;
    end
    for (int c = 0; c < 200 && !finished; c++) begin
      feed_ok = msg_valid_i && msg_ready_o;
      pop_ok  = pageWr_en_o && pageWr_ready_i;
      if (started && wr_k <= last_k && !pageWr_en_o) bubbles++;
      if (pop_ok) begin
        started = 1;
        check("wr_addr", 128'(pageWr_addr_o), 128'(addr_of(wr_k)));
        check("wr_data", 128'(pageWr_data_o), 128'(exp_data(wr_k)));
        last_wr = c;
      end
      if (layer_done_o) begin
        done_cnt++;
        check("done_after_last_write", 128'(c), 128'(last_wr + 1));
      end
      tick;
      if (done_cnt != 0) begin
        check("busy_after_done", 128'(busy_o), 128'(0));
        check("done_one_cycle", 128'(layer_done_o), 128'(0));
        finished = 1;
      end
      if (feed_ok) begin
        feed_k++;
        if (feed_k <= last_k) drive_beat(feed_k);
        else msg_valid_i = 1'b0;
      end
      if (pop_ok) wr_k++;
    end
    msg_valid_i = 1'b0;
    check("write_count", 128'(wr_k), 128'(last_k + 1));
    check("done_count", 128'(done_cnt), 128'(1));
    check("bubbles", 128'(bubbles), 128'(0));
  endtask

  initial begin
    int idx;
    logic [67:0] d;
    rst = 1'b1;
    msg_bit0_i = '0; msg_bit1_i = '0; msg_bit2_i = '0; msg_bit3_i = '0;
    msg_page_addr_i = '0; msg_valid_i = 1'b0; layer_start_i = 1'b0;
    layer_len_i = '0; pageWr_ready_i = 1'b1;
    @(negedge sys_clk);
    tick;
    tick;
    rst = 1'b0;

    // Reset state
    check("rst_ready", 128'(msg_ready_o), 128'(0));
    check("rst_en", 128'(pageWr_en_o), 128'(0));
    check("rst_data", 128'(pageWr_data_o), 128'(0));
    check("rst_addr", 128'(pageWr_addr_o), 128'(0));
    check("rst_done", 128'(layer_done_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_err", 128'(err_o), 128'(0));

    // Single beat
    start_layer(1);
    check("sb_busy", 128'(busy_o), 128'(1));
    check("sb_ready", 128'(msg_ready_o), 128'(1));
    drive_beat(0);
    msg_valid_i = 1'b1;
    tick;
    msg_valid_i = 1'b0;
    d = pageWr_data_o;
    check("sb_en", 128'(pageWr_en_o), 128'(1));
    check("sb_lane0", 128'(d[3:0]), 128'(4'hA));
    check("sb_lane16", 128'(d[67:64]), 128'(4'h5));
    check("sb_data", 128'(d), 128'(exp_data(0)));
    check("sb_addr", 128'(pageWr_addr_o), 128'(3));
    check("sb_no_early_done", 128'(layer_done_o), 128'(0));
    tick;
    check("sb_done", 128'(layer_done_o), 128'(1));
    check("sb_en_after", 128'(pageWr_en_o), 128'(0));
    tick;
    check("sb_done_clear", 128'(layer_done_o), 128'(0));
    check("sb_idle", 128'(busy_o), 128'(0));

    // Backpressure: only FIFO_DEPTH beats accepted while the RAM stalls
    pageWr_ready_i = 1'b0;
    start_layer(8);
    idx = 1;
    drive_beat(idx);
    msg_valid_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bit acc;
      acc = msg_ready_o;
      tick;
      if (acc) begin
        idx++;
        drive_beat(idx);
      end
    end
    check("bp_accepted", 128'(idx - 1), 128'(4));
    check("bp_ready_low", 128'(msg_ready_o), 128'(0));
    check("bp_en", 128'(pageWr_en_o), 128'(1));
    check("bp_head_addr", 128'(pageWr_addr_o), 128'(addr_of(1)));
    check("bp_head_data", 128'(pageWr_data_o), 128'(exp_data(1)));
    pageWr_ready_i = 1'b1;
    stream(idx, 1, 8);
    check("bp_err", 128'(err_o), 128'(0));

    // Streaming 20 beats through a 4-deep FIFO
    start_layer(20);
    stream(10, 10, 29);

    // layer_start_i during RUN is ignored and flagged
    check("pe_err_before", 128'(err_o), 128'(0));
    pageWr_ready_i = 1'b0;
    start_layer(2);
    drive_beat(41);
    msg_valid_i = 1'b1;
    tick;
    drive_beat(42);
    layer_start_i = 1'b1;
    layer_len_i   = 8'd9;
    tick;
    layer_start_i = 1'b0;
    msg_valid_i   = 1'b0;
    check("pe_err_start", 128'(err_o), 128'(1));
    check("pe_busy", 128'(busy_o), 128'(1));
    check("pe_ready_drain", 128'(msg_ready_o), 128'(0));
    pageWr_ready_i = 1'b1;
    stream(43, 41, 42);

    // Zero-length layer
    start_layer(0);
    check("zl_busy", 128'(busy_o), 128'(1));
    check("zl_ready", 128'(msg_ready_o), 128'(0));
    check("zl_no_done_yet", 128'(layer_done_o), 128'(0));
    tick;
    check("zl_done", 128'(layer_done_o), 128'(1));
    check("zl_no_write", 128'(pageWr_en_o), 128'(0));
    tick;
    check("zl_idle", 128'(busy_o), 128'(0));

    // Reset with 3 entries queued
    pageWr_ready_i = 1'b0;
    start_layer(5);
    msg_valid_i = 1'b1;
    for (int k = 50; k < 53; k++) begin
      drive_beat(k);
      tick;
    end
    msg_valid_i = 1'b0;
    check("mr_en_before", 128'(pageWr_en_o), 128'(1));
    check("mr_busy_before", 128'(busy_o), 128'(1));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    pageWr_ready_i = 1'b1;
    check("mr_en", 128'(pageWr_en_o), 128'(0));
    check("mr_busy", 128'(busy_o), 128'(0));
    check("mr_err", 128'(err_o), 128'(0));
    check("mr_data", 128'(pageWr_data_o), 128'(0));
    check("mr_ready", 128'(msg_ready_o), 128'(0));
    for (int c = 0; c < 3; c++) begin
      check("mr_no_done", 128'(layer_done_o), 128'(0));
      tick;
    end

    // Valid while IDLE is dropped and flagged
    drive_beat(60);
    msg_valid_i = 1'b1;
    tick;
    msg_valid_i = 1'b0;
    check("iv_err", 128'(err_o), 128'(1));
    check("iv_no_write", 128'(pageWr_en_o), 128'(0));
    tick;
    check("iv_no_write_later", 128'(pageWr_en_o), 128'(0));
    check("iv_idle", 128'(busy_o), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
